// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter
//   Two-requester round-robin arbiter driving a shared 2:1 data mux.
//   Grants, the mux select and the last-owner record are registered.
//   The data path from a/b to y is combinational, so the owner's data
//   reaches y in the cycle it changes.
//
//   Optional feature, macro ARB_TIMEOUT_EN:
//     With the macro defined, a hold counter limits a grant to HOLD_MAX
//     cycles whenever the other requester is waiting.
//     With the macro undefined, a grant lasts as long as its owner requests.
//
//   Parameters
//     WIDTH     data width of a, b and y
//     HOLD_MAX  maximum grant length in cycles (2..255); used only with
//               ARB_TIMEOUT_EN
//
//   Ports
//     clk          rising-edge clock
//     rst_n        asynchronous active-low reset
//     req_a/req_b  requests, held high while access is needed
//     a/b          requester data
//     gnt_a/gnt_b  registered grants, never both high
//     sel          registered mux select (0 = a, 1 = b)
//     valid        gnt_a | gnt_b
//     y            granted data, zero when idle
module mux2_rr_arbiter #(
    parameter int WIDTH    = 8,
    parameter int HOLD_MAX = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             sel,
    output logic             valid,
    output logic [WIDTH-1:0] y
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GNT_A = 2'd1;
    localparam logic [1:0] GNT_B = 2'd2;

    localparam logic OWNER_A = 1'b0;
    localparam logic OWNER_B = 1'b1;

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       last;
    logic       enter_grant;
    logic       hold_expired;

    // Next-state decision. hold_expired is high only when the timeout
    // feature is built in and the current grant has used up its slot.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_a && req_b) begin
                    state_nxt = (last == OWNER_B) ? GNT_A : GNT_B;
                end else if (req_a) begin
                    state_nxt = GNT_A;
                end else if (req_b) begin
                    state_nxt = GNT_B;
                end else begin
                    state_nxt = IDLE;
                end
            end
            GNT_A: begin
                if (req_a && !(req_b && hold_expired)) begin
                    state_nxt = GNT_A;
                end else if (req_b) begin
                    state_nxt = GNT_B;
                end else begin
                    state_nxt = IDLE;
                end
            end
            GNT_B: begin
                if (req_b && !(req_a && hold_expired)) begin
                    state_nxt = GNT_B;
                end else if (req_a) begin
                    state_nxt = GNT_A;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A new ownership period starts whenever the next state is a grant
    // state different from the current one (IDLE->GNT_x or GNT_x->GNT_y).
    assign enter_grant = (state_nxt != IDLE) && (state_nxt != state);

    // Grants and select are registered copies of the next state, so no
    // combinational path exists from req to gnt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            gnt_a <= 1'b0;
            gnt_b <= 1'b0;
            sel   <= 1'b0;
            last  <= OWNER_B;   // A wins the first tie after reset
        end else begin
            state <= state_nxt;
            gnt_a <= (state_nxt == GNT_A);
            gnt_b <= (state_nxt == GNT_B);
            sel   <= (state_nxt == GNT_B);
            if (enter_grant) begin
                last <= (state_nxt == GNT_B) ? OWNER_B : OWNER_A;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    logic [7:0] hold_cnt;

    // Counts cycles the current grant has been held; saturates at
    // HOLD_LAST so an uncontested owner keeps the path indefinitely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= 8'd0;
        end else if (enter_grant) begin
            hold_cnt <= 8'd0;
        end else if ((state != IDLE) && (state_nxt == state) &&
                     (hold_cnt != HOLD_LAST)) begin
            hold_cnt <= hold_cnt + 8'd1;
        end
    end

    assign hold_expired = (hold_cnt == HOLD_LAST);
`else
    // No timeout: a grant never expires while its owner requests.
    // HOLD_MAX below 2 is outside the legal range and never selected.
    assign hold_expired = (HOLD_MAX < 2);
`endif

    assign valid = gnt_a | gnt_b;

    // Shared output mux; zero whenever nobody owns the path.
    always_comb begin
        y = '0;
        if (gnt_a && !sel) begin
            y = a;
        end else if (gnt_b && sel) begin
            y = b;
        end
    end

endmodule

// File: doc/mux2_rr_arbiter.md
MUX2_RR_ARBITER -- requirements
Module: mux2_rr_arbiter

Interface
REQ-001 Parameter: WIDTH, default 8, data width of both inputs and the output.
REQ-002 Parameter: HOLD_MAX, default 15, maximum grant length in cycles; only used when ARB_TIMEOUT_EN is defined; legal range 2..255.
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: req_a  input  1  requester A wants the shared path; held high for as long as it needs access.
REQ-006 Port: req_b  input  1  requester B wants the shared path; same rules as req_a.
REQ-007 Port: a  input  WIDTH  data from requester A.
REQ-008 Port: b  input  WIDTH  data from requester B.
REQ-009 Port: gnt_a  output  1  A owns the path (registered).
REQ-010 Port: gnt_b  output  1  B owns the path (registered).
REQ-011 Port: sel  output  1  registered mux select; 0 = a, 1 = b.
REQ-012 Port: valid  output  1  high when y carries granted data; equals gnt_a | gnt_b.
REQ-013 Port: y  output  WIDTH  shared output; a when gnt_a, b when gnt_b, all-zero when idle.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, GNT_A, GNT_B; gnt_a=1 only in GNT_A, gnt_b=1 only in GNT_B.
REQ-015 gnt_a and gnt_b SHALL never be high together.
REQ-016 IDLE: req_a only -> GNT_A; req_b only -> GNT_B; neither -> stay in IDLE.
REQ-017 IDLE, both requests high: grant the requester that is not recorded in the last-owner register (last), i.e. round-robin.
REQ-018 last SHALL update to the new owner on every entry into GNT_A or GNT_B.
REQ-019 Grant latency: a request seen at edge N SHALL give its grant at edge N+1; no combinational path from any req to any gnt.
REQ-020 GNT_A while req_a high: stay in GNT_A (apart from REQ-026). GNT_B mirrors this rule.
REQ-021 GNT_A, req_a low and req_b high: go directly to GNT_B with no idle gap. GNT_B mirrors this rule.
REQ-022 GNT_x, both requests low: go to IDLE.
REQ-023 sel SHALL be 1 in GNT_B and 0 in both GNT_A and IDLE; sel changes only on the clock edge.
REQ-024 y SHALL be combinational from sel, gnt_a, gnt_b, a and b; data changes on a or b during a grant SHALL reach y in the same cycle.

Reset
REQ-025 While rst_n is low, and at once when it goes low (including mid-grant), the block SHALL force:
- state = IDLE
- gnt_a = 0, gnt_b = 0, sel = 0, valid = 0, y = 0
- last = B, so A wins the first tie
- hold counter = 0
The first grant SHALL come no earlier than the first rising edge after rst_n goes high.

Configuration
REQ-026 Macro ARB_TIMEOUT_EN defined:
- A hold counter clears on entry into any grant state and increments each cycle the grant is held.
- When the counter has reached HOLD_MAX-1 and the other request is high, the grant SHALL pass to the other requester on the next edge, even if the current owner still requests.
- If the other request is low, the grant is kept and the counter saturates.
REQ-027 Macro ARB_TIMEOUT_EN undefined: no counter logic; a grant is held for as long as its owner requests (REQ-020).

Verification
REQ-028 Reset, then req_a=1, a=8'h5A, req_b=0 -> gnt_a=1, sel=0, valid=1, y=8'h5A one edge later; y=0 and valid=0 before that edge.
REQ-029 From IDLE after reset, req_a=req_b=1 at the same edge -> gnt_a first; drop req_a -> gnt_b=1, sel=1, y=b at the next edge with no IDLE cycle; drop req_b, then raise both again -> gnt_a (round-robin).
REQ-030 In GNT_B, pull rst_n low between clock edges -> gnt_b, sel, valid and y go to 0 at once; after release with req_a=req_b=1 -> gnt_a wins.
REQ-031 ARB_TIMEOUT_EN, HOLD_MAX=4, both requests held high -> grants switch A,B,A,... every 4 cycles and never overlap; without the macro, gnt_a stays high indefinitely.
REQ-032 In GNT_A, change a from 8'h00 to 8'hFF in the middle of a cycle -> y=8'hFF in the same cycle and gnt_a does not change.
